// File: rtl/issue_perf_monitor.sv
// issue_perf_monitor: issue-stage performance counters (reorder histogram, no-ISB stalls,
// per-channel occupancy utilisation and allocation period) with optional snapshot shadows.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_issue_valid/_dist   issued instruction and its reorder distance (0 = in order)
//   i_noisb_stall         issue stalled for lack of an ISB entry
//   i_occ                 per-channel occupancy, channel i at [i*OCC_BITS +: OCC_BITS]
//   i_clr_req             zero all counters and flush the input stage
//   i_snap_req            capture counters into the output shadows
//   o_reorders            issues with non-zero distance
//   o_reorder_hist        bin b (1-based) at [(b-1)*CTR_BITS +: CTR_BITS]
//   o_noisb_stalls        stall-cycle count
//   o_util                per-channel accumulated occupancy
//   o_alloc_period        per-channel 64-bit count of cycles with non-zero occupancy
//   o_snap_valid          one-cycle pulse following a snapshot request
module issue_perf_monitor #(
   parameter int NUM_BINS  = 15,
   parameter int DIST_BITS = 4,
   parameter int NUM_CH    = 2,
   parameter int OCC_BITS  = 5,
   parameter int CTR_BITS  = 44,
   parameter int SATURATE  = 1,
   parameter int SNAPSHOT  = 0
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_issue_valid,
   input  logic [DIST_BITS-1:0]         i_issue_dist,
   input  logic                         i_noisb_stall,
   input  logic [NUM_CH*OCC_BITS-1:0]   i_occ,
   input  logic                         i_clr_req,
   input  logic                         i_snap_req,
   output logic [CTR_BITS-1:0]          o_reorders,
   output logic [NUM_BINS*CTR_BITS-1:0] o_reorder_hist,
   output logic [CTR_BITS-1:0]          o_noisb_stalls,
   output logic [NUM_CH*CTR_BITS-1:0]   o_util,
   output logic [NUM_CH*64-1:0]         o_alloc_period,
   output logic                         o_snap_valid
);
   logic                       r_v, r_stall, r_snap_valid;
   logic [DIST_BITS-1:0]       r_dist;
   logic [NUM_CH*OCC_BITS-1:0] r_occ;
   logic [CTR_BITS-1:0]        r_reo, r_stalls, r_sh_reo, r_sh_stalls;
   logic [CTR_BITS-1:0]        r_hist [NUM_BINS];
   logic [CTR_BITS-1:0]        r_sh_hist [NUM_BINS];
   logic [CTR_BITS-1:0]        r_util [NUM_CH];
   logic [CTR_BITS-1:0]        r_sh_util [NUM_CH];
   logic [63:0]                r_alloc [NUM_CH];
   logic [63:0]                r_sh_alloc [NUM_CH];
   logic [31:0]                w_dist;
   logic                       w_reo;
   logic [NUM_BINS-1:0]        w_hit;
   // Overflow from a wide sum either clamps to all-ones or wraps, never partially.
   function automatic logic [CTR_BITS-1:0] f_add(input logic [CTR_BITS-1:0] a, input logic [CTR_BITS-1:0] b);
      logic [CTR_BITS:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (SATURATE != 0 && s[CTR_BITS]) ? {CTR_BITS{1'b1}} : s[CTR_BITS-1:0];
   endfunction
   assign w_dist = 32'(r_dist);
   assign w_reo  = r_v && (r_dist != '0);
   // The last bin also absorbs every distance beyond the histogram range.
   always_comb begin
      w_hit = '0;
      for (int b = 0; b < NUM_BINS; b++)
         w_hit[b] = w_reo && ((b == NUM_BINS - 1) ? (w_dist >= 32'(NUM_BINS)) : (w_dist == 32'(b + 1)));
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_v          <= 1'b0;
         r_stall      <= 1'b0;
         r_dist       <= '0;
         r_occ        <= '0;
         r_snap_valid <= 1'b0;
         r_reo        <= '0;
         r_stalls     <= '0;
         r_sh_reo     <= '0;
         r_sh_stalls  <= '0;
         for (int b = 0; b < NUM_BINS; b++) begin
            r_hist[b]    <= '0;
            r_sh_hist[b] <= '0;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            r_util[c]     <= '0;
            r_sh_util[c]  <= '0;
            r_alloc[c]    <= '0;
            r_sh_alloc[c] <= '0;
         end
      end else begin
         r_snap_valid <= i_snap_req;
         // Shadows take the pre-update values, so a same-cycle clear cannot wipe them.
         if (SNAPSHOT != 0 && i_snap_req) begin
            r_sh_reo    <= r_reo;
            r_sh_stalls <= r_stalls;
            for (int b = 0; b < NUM_BINS; b++)
               r_sh_hist[b] <= r_hist[b];
            for (int c = 0; c < NUM_CH; c++) begin
               r_sh_util[c]  <= r_util[c];
               r_sh_alloc[c] <= r_alloc[c];
            end
         end
         if (i_clr_req) begin
            r_v      <= 1'b0;
            r_stall  <= 1'b0;
            r_dist   <= '0;
            r_occ    <= '0;
            r_reo    <= '0;
            r_stalls <= '0;
            for (int b = 0; b < NUM_BINS; b++)
               r_hist[b] <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
               r_util[c]  <= '0;
               r_alloc[c] <= '0;
            end
         end else begin
            r_v      <= i_issue_valid;
            r_stall  <= i_noisb_stall;
            r_dist   <= i_issue_dist;
            r_occ    <= i_occ;
            r_reo    <= f_add(r_reo, CTR_BITS'(w_reo));
            r_stalls <= f_add(r_stalls, CTR_BITS'(r_stall));
            for (int b = 0; b < NUM_BINS; b++)
               r_hist[b] <= f_add(r_hist[b], CTR_BITS'(w_hit[b]));
            for (int c = 0; c < NUM_CH; c++) begin
               r_util[c]  <= f_add(r_util[c], CTR_BITS'(r_occ[c*OCC_BITS +: OCC_BITS]));
               r_alloc[c] <= r_alloc[c] + 64'(|r_occ[c*OCC_BITS +: OCC_BITS]);
            end
         end
      end
   end
   assign o_snap_valid   = r_snap_valid;
   assign o_reorders     = (SNAPSHOT != 0) ? r_sh_reo : r_reo;
   assign o_noisb_stalls = (SNAPSHOT != 0) ? r_sh_stalls : r_stalls;
   for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
      assign o_reorder_hist[b*CTR_BITS +: CTR_BITS] = (SNAPSHOT != 0) ? r_sh_hist[b] : r_hist[b];
   end
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign o_util[c*CTR_BITS +: CTR_BITS] = (SNAPSHOT != 0) ? r_sh_util[c] : r_util[c];
      assign o_alloc_period[c*64 +: 64]     = (SNAPSHOT != 0) ? r_sh_alloc[c] : r_alloc[c];
   end
endmodule

// File: tb/tb_issue_perf_monitor.sv
// tb_issue_perf_monitor: random stimulus on a live/saturating and a snapshot/wrapping instance against a sum-based model.
module tb_issue_perf_monitor;
   localparam int NB = 8;
   localparam int DB = 4;
   localparam int NCH = 2;
   localparam int OB = 3;
   localparam int CW = 7;
   localparam longint MAXV = (64'd1 << CW) - 1;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic issue_valid = 1'b0;
   logic [DB-1:0] issue_dist = '0;
   logic noisb_stall = 1'b0;
   logic [NCH*OB-1:0] occ = '0;
   logic clr_req = 1'b0;
   logic snap_req = 1'b0;
   logic [CW-1:0] a_reo, a_stall, b_reo, b_stall;
   logic [NB*CW-1:0] a_hist, b_hist;
   logic [NCH*CW-1:0] a_util, b_util;
   logic [NCH*64-1:0] a_alloc, b_alloc;
   logic a_sv, b_sv;
   int n_vec = 0;
   int n_err = 0;
   int mode = 0;
   longint m_reo, m_stall, s_reo, s_stall;
   longint m_hist[NB];
   longint s_hist[NB];
   longint m_util[NCH];
   longint s_util[NCH];
   longint m_alloc[NCH];
   longint s_alloc[NCH];
   bit m_sv, p_ok, p_v, p_s;
   int p_d;
   int p_occ[NCH];
   always #5 clk = ~clk;
   issue_perf_monitor #(.NUM_BINS(NB), .DIST_BITS(DB), .NUM_CH(NCH), .OCC_BITS(OB), .CTR_BITS(CW),
                        .SATURATE(1), .SNAPSHOT(0)) u_live (
      .i_clk(clk), .i_reset(reset), .i_issue_valid(issue_valid), .i_issue_dist(issue_dist),
      .i_noisb_stall(noisb_stall), .i_occ(occ), .i_clr_req(clr_req), .i_snap_req(snap_req),
      .o_reorders(a_reo), .o_reorder_hist(a_hist), .o_noisb_stalls(a_stall), .o_util(a_util),
      .o_alloc_period(a_alloc), .o_snap_valid(a_sv));
   issue_perf_monitor #(.NUM_BINS(NB), .DIST_BITS(DB), .NUM_CH(NCH), .OCC_BITS(OB), .CTR_BITS(CW),
                        .SATURATE(0), .SNAPSHOT(1)) u_snap (
      .i_clk(clk), .i_reset(reset), .i_issue_valid(issue_valid), .i_issue_dist(issue_dist),
      .i_noisb_stall(noisb_stall), .i_occ(occ), .i_clr_req(clr_req), .i_snap_req(snap_req),
      .o_reorders(b_reo), .o_reorder_hist(b_hist), .o_noisb_stalls(b_stall), .o_util(b_util),
      .o_alloc_period(b_alloc), .o_snap_valid(b_sv));
   function automatic longint vsat(input longint v);
      return (v > MAXV) ? MAXV : v;
   endfunction
   function automatic longint vwrap(input longint v);
      return v % (MAXV + 1);
   endfunction
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   // A counter after edge t holds the sum of events from cycles after the last clear/reset up to t-1.
   task automatic update_model();
      if (reset) begin
         m_reo = 0; m_stall = 0; s_reo = 0; s_stall = 0; m_sv = 0; p_ok = 0;
         for (int b = 0; b < NB; b++) begin m_hist[b] = 0; s_hist[b] = 0; end
         for (int c = 0; c < NCH; c++) begin m_util[c] = 0; s_util[c] = 0; m_alloc[c] = 0; s_alloc[c] = 0; end
      end else begin
         m_sv = snap_req;
         if (snap_req) begin
            s_reo = vwrap(m_reo);
            s_stall = vwrap(m_stall);
            for (int b = 0; b < NB; b++) s_hist[b] = vwrap(m_hist[b]);
            for (int c = 0; c < NCH; c++) begin s_util[c] = vwrap(m_util[c]); s_alloc[c] = m_alloc[c]; end
         end
         if (clr_req) begin
            m_reo = 0; m_stall = 0;
            for (int b = 0; b < NB; b++) m_hist[b] = 0;
            for (int c = 0; c < NCH; c++) begin m_util[c] = 0; m_alloc[c] = 0; end
         end else if (p_ok) begin
            if (p_v && p_d != 0) begin
               m_reo++;
               m_hist[(p_d >= NB ? NB : p_d) - 1]++;
            end
            if (p_s) m_stall++;
            for (int c = 0; c < NCH; c++) begin
               m_util[c] += p_occ[c];
               if (p_occ[c] != 0) m_alloc[c]++;
            end
         end
         p_ok = !clr_req;
      end
      p_v = issue_valid;
      p_d = int'(issue_dist);
      p_s = noisb_stall;
      for (int c = 0; c < NCH; c++) p_occ[c] = int'(occ[c*OB +: OB]);
   endtask
   task automatic check_all();
      check("live_reorders", 64'(a_reo), vsat(m_reo));
      check("live_stalls", 64'(a_stall), vsat(m_stall));
      check("live_snap_valid", 64'(a_sv), 64'(m_sv));
      check("snap_reorders", 64'(b_reo), s_reo);
      check("snap_stalls", 64'(b_stall), s_stall);
      check("snap_valid", 64'(b_sv), 64'(m_sv));
      for (int b = 0; b < NB; b++) begin
         check($sformatf("live_bin%0d", b + 1), 64'(a_hist[b*CW +: CW]), vsat(m_hist[b]));
         check($sformatf("snap_bin%0d", b + 1), 64'(b_hist[b*CW +: CW]), s_hist[b]);
      end
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("live_util%0d", c), 64'(a_util[c*CW +: CW]), vsat(m_util[c]));
         check($sformatf("live_alloc%0d", c), a_alloc[c*64 +: 64], m_alloc[c]);
         check($sformatf("snap_util%0d", c), 64'(b_util[c*CW +: CW]), s_util[c]);
         check($sformatf("snap_alloc%0d", c), b_alloc[c*64 +: 64], s_alloc[c]);
      end
   endtask
   initial begin
      for (int t = 0; t < 3000; t++) begin
         @(posedge clk);
         update_model();
         #1;
         if (t % 200 == 0) mode = int'($urandom_range(0, 2));
         reset = (t < 2) || ($urandom_range(0, 299) == 0);
         clr_req = (mode == 2) ? 1'b0 : (mode == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 63) == 0);
         snap_req = (mode == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
         issue_valid = ($urandom_range(0, 3) != 0);
         issue_dist = DB'($urandom_range(0, 15));
         noisb_stall = (mode == 2) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
         for (int c = 0; c < NCH; c++)
            occ[c*OB +: OB] = ($urandom_range(0, 2) == 0) ? '0 : OB'($urandom_range(1, 7));
         @(negedge clk);
         check_all();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/issue_perf_monitor.md
Name: issue_perf_monitor

Overview:
- Parametrised issue-stage performance monitor: collects reorder-distance histogram, no-ISB stall count and per-channel occupancy utilisation/allocation-period counters.
- Sits beside the issue stage; its outputs drive the issue-side fields of the pipeline perf bundle.
- Successor to the fixed 15-bin, two-buffer counters: configurable bin count, channel count, counter width, saturation, snapshot mode and synchronous clear.

Parameters:
- NUM_BINS, 15, histogram bins 1..NUM_BINS; bin NUM_BINS is the overflow bin (>=2)
- DIST_BITS, 4, width of the reorder-distance input
- NUM_CH, 2, number of occupancy channels (ISB, in-flight, ...)
- OCC_BITS, 5, occupancy input width per channel
- CTR_BITS, 44, event/utilisation counter width (PERF_CTR_BITS)
- SATURATE, 1, 1 = counters stick at all-ones; 0 = wrap modulo 2^CTR_BITS
- SNAPSHOT, 0, 0 = outputs are live counters; 1 = outputs are shadow registers loaded on snap_req

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  an instruction issued this cycle
- issue_dist  in  DIST_BITS  reorder distance of the issued instruction (0 = in order)
- noisb_stall  in  1  issue stalled for lack of an ISB entry this cycle
- occ  in  NUM_CH*OCC_BITS  per-channel occupancy this cycle, channel i at [i*OCC_BITS +: OCC_BITS]
- clr_req  in  1  clear all counters
- snap_req  in  1  capture counters into outputs (used when SNAPSHOT=1)
- reorders  out  CTR_BITS  count of issues with dist != 0
- reorder_hist  out  NUM_BINS*CTR_BITS  bin b (1-based) at [(b-1)*CTR_BITS +: CTR_BITS]
- noisb_stalls  out  CTR_BITS  stall-cycle count
- util  out  NUM_CH*CTR_BITS  per-channel accumulated occupancy sum
- alloc_period  out  NUM_CH*64  per-channel cycles with occ != 0
- snap_valid  out  1  one-cycle pulse: outputs updated by snapshot

Behaviour:
- Reset: every counter, shadow register, input-stage register, all outputs and snap_valid are 0 on the first edge with reset=1. Reset takes priority over clr_req and snap_req.
- Pipeline:
  - Stage 1 registers issue_valid, issue_dist, noisb_stall and occ.
  - Stage 2 updates the counters from the stage-1 values.
  - An event presented in cycle k is visible on live counters after the edge ending cycle k+1 (2-edge latency).
- Binning, applied only when issue_valid=1:
  - dist = 0: no update.
  - 1 <= dist <= NUM_BINS-1: reorders+1 and bin dist +1.
  - dist >= NUM_BINS: reorders+1 and bin NUM_BINS +1.
  - Exactly one bin increments per valid reorder.
- noisb_stalls: +1 per stage-1 cycle with noisb_stall=1. The issue_valid and noisb_stall inputs are independent; both may be set in the same cycle.
- Utilisation, per channel i, every cycle:
  - util[i] += occ[i], zero-extended to CTR_BITS.
  - alloc_period[i] += 1 when occ[i] != 0.
- Width and saturation:
  - Event and util counters obey SATURATE. With SATURATE=1, util clamps at all-ones when the addition would overflow (no partial wrap).
  - alloc_period is 64-bit and always wraps.
- clr_req in cycle c:
  - On the edge ending c, all counters are zeroed and stage 1 is flushed.
  - Events presented in cycles c-1 and c are discarded; events from cycle c+1 onward are counted.
  - Shadow registers are not cleared by clr_req.
- Snapshot, SNAPSHOT=1:
  - snap_req in cycle s loads the shadows with the counter values held during cycle s, i.e. pre-update, excluding the stage-2 event of cycle s.
  - snap_valid=1 during cycle s+1.
  - Outputs hold between snapshots.
- Snapshot, SNAPSHOT=0:
  - Outputs equal the live counters.
  - snap_valid still pulses one cycle after snap_req.
- snap_req and clr_req in the same cycle: shadows capture the pre-clear values, then the counters clear. Nothing is lost or double-counted.
- Back-to-back snap_req: every request captures and pulses snap_valid. There is no coalescing.
- Reset mid-operation: in-flight stage-1 events are dropped; there is no partial update.

Test Plan:
- Reorder histogram, NUM_BINS=15: issue_valid=1 with dist 0,1,3,15,9 on consecutive cycles -> reorders=4; bins 1, 3, 9, 15 each =1; all other bins 0; final values visible 2 edges after the last input.
- Overflow bin, NUM_BINS=8, DIST_BITS=4: dist=12, then dist=8 -> bin 8 =2, reorders=2; dist=7 -> bin 7 =1.
- Saturation, CTR_BITS=4: 20 cycles of noisb_stall=1.
  - SATURATE=1 -> noisb_stalls=15.
  - SATURATE=0 -> noisb_stalls=4.
  - util with occ=9 for 3 cycles and SATURATE=1 -> 15.
- Occupancy, NUM_CH=2:
  - ch0 occ 3,0,5 and ch1 occ 0,0,1 -> util0=8, alloc0=2, util1=1, alloc1=1.
- Clear: 10 reorders, then clr_req in cycle c with valid reorders in c-1, c and c+1 -> reorders=1 afterwards.
- Snapshot, SNAPSHOT=1: counters at reorders=6, snap_req with clr_req in the same cycle -> output reorders=6 and snap_valid pulses next cycle. Live counter is 0; the next snap_req after 2 reorders outputs 2.
- Reset mid-stream: reset asserted one cycle after a valid reorder -> all outputs 0; no late increment appears after reset deasserts.
